// File: rtl/ahb_rr_arbiter.sv
// N-way arbiter that selects which channel front-end owns the single AHB master port.
// Round-robin or fixed priority, with an optional per-owner burst lock capped at MAX_BEATS.
module ahb_rr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     h_clk_en,
  input  logic                     h_ready,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     busy
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);
  localparam logic [CntW-1:0] BeatLast = CntW'(MAX_BEATS - 1);
  localparam logic [IdxW-1:0] PtrInit  = IdxW'(N_REQ - 1);

  typedef enum logic {StIdle, StOwned} state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   ptr_q;
  logic [CntW-1:0]   beat_q;
  logic              busy_q;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic              retain;

  // Winner selection; loops run high-to-low so the last hit is the highest-priority one.
  always_comb begin
    int unsigned j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    if (PRIO_MODE == 1) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_found = 1'b1;
          win_idx   = IdxW'(i);
        end
      end
    end else begin
      for (int unsigned k = N_REQ; k >= 1; k--) begin
        j = (32'(ptr_q) + k) % N_REQ;
        if (req[j[IdxW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = j[IdxW-1:0];
        end
      end
    end
  end

  // With MAX_BEATS == 1 BeatLast is zero, so the owner can never retain.
  assign retain = lock[idx_q] & req[idx_q] & (beat_q < BeatLast);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= PtrInit;
      beat_q  <= '0;
      busy_q  <= 1'b0;
    end else if (h_clk_en) begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q          <= StOwned;
            grant_q          <= '0;
            grant_q[win_idx] <= 1'b1;
            idx_q            <= win_idx;
            ptr_q            <= win_idx;
            beat_q           <= '0;
            busy_q           <= 1'b1;
          end
        end
        StOwned: begin
          // h_ready low: data phase still in progress, grant is held regardless of req.
          if (h_ready) begin
            if (retain) begin
              beat_q <= beat_q + 1'b1;
            end else if (win_found) begin
              grant_q          <= '0;
              grant_q[win_idx] <= 1'b1;
              idx_q            <= win_idx;
              ptr_q            <= win_idx;
              beat_q           <= '0;
            end else begin
              state_q <= StIdle;
              grant_q <= '0;
              beat_q  <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;

endmodule
